// File: rtl/atod_digital_if.sv
// Bus between the dual-channel SAR controller and its analog front end.
//   strt_cnv  : conversion request
//   gt_cos    : cos comparator result, 1 when cosSAR > sampled cos
//   gt_sin    : sin comparator result, 1 when sinSAR > sampled sin
//   smpl      : sample/hold control; its falling edge captures both inputs
//   cosSAR    : cos DAC trial word
//   sinSAR    : sin DAC trial word
//   cos_val   : last completed cos result
//   sin_val   : last completed sin result
//   busy      : high while a conversion is in progress
//   cnv_cmplt : one-cycle pulse when cos_val/sin_val update
// master = digital controller, slave = analog front end / requester.
interface atod_digital_if;
  logic        strt_cnv;
  logic        gt_cos;
  logic        gt_sin;
  logic        smpl;
  logic [11:0] cosSAR;
  logic [11:0] sinSAR;
  logic [11:0] cos_val;
  logic [11:0] sin_val;
  logic        busy;
  logic        cnv_cmplt;

  modport master (
    input  strt_cnv, gt_cos, gt_sin,
    output smpl, cosSAR, sinSAR, cos_val, sin_val, busy, cnv_cmplt
  );

  modport slave (
    output strt_cnv, gt_cos, gt_sin,
    input  smpl, cosSAR, sinSAR, cos_val, sin_val, busy, cnv_cmplt
  );
endinterface

// File: rtl/atod_digital.sv
// Dual-channel 12-bit successive-approximation controller (cos and sin in lockstep).
// A request in idle holds smpl high for SMPL_CYCLES cycles, then walks the trial bit from
// 11 down to 0, holding each trial word for SETTLE cycles before reading the comparators.
// Ports:
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : atod_digital_if master modport (request, comparators, DAC words, results)
module atod_digital #(
  parameter int unsigned SMPL_CYCLES = 4,  // 1..15
  parameter int unsigned SETTLE      = 2   // 1..7
) (
  input logic            clk,
  input logic            rst_n,
  atod_digital_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSample, StConv, StDone} state_e;

  localparam logic [3:0] SmplLast   = 4'(SMPL_CYCLES - 1);
  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [11:0] cos_sar_q, cos_sar_d;
  logic [11:0] sin_sar_q, sin_sar_d;
  logic [11:0] cos_val_q, cos_val_d;
  logic [11:0] sin_val_q, sin_val_d;
  logic        smpl_q, smpl_d;
  logic        busy_q, busy_d;
  logic        cmplt_q, cmplt_d;

  // Comparator high means the trial overshoots, so drop the bit; then try the next one down.
  function automatic logic [11:0] resolve(input logic [11:0] sar, input logic [3:0] idx,
                                          input logic gt);
    logic [11:0] r;
    r = sar;
    if (gt) r[idx] = 1'b0;
    if (idx != 4'd0) r[idx - 4'd1] = 1'b1;
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    cos_sar_d = cos_sar_q;
    sin_sar_d = sin_sar_q;
    cos_val_d = cos_val_q;
    sin_val_d = sin_val_q;
    smpl_d    = smpl_q;
    busy_d    = busy_q;
    cmplt_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.strt_cnv) begin
          state_d   = StSample;
          cnt_d     = 4'd0;
          idx_d     = 4'd11;
          smpl_d    = 1'b1;
          busy_d    = 1'b1;
          cos_sar_d = 12'h000;
          sin_sar_d = 12'h000;
        end
      end
      StSample: begin
        if (cnt_q == SmplLast) begin
          state_d   = StConv;
          cnt_d     = 4'd0;
          idx_d     = 4'd11;
          smpl_d    = 1'b0;
          cos_sar_d = 12'h800;
          sin_sar_d = 12'h800;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StConv: begin
        if (cnt_q == SettleLast) begin
          cnt_d     = 4'd0;
          cos_sar_d = resolve(cos_sar_q, idx_q, bus.gt_cos);
          sin_sar_d = resolve(sin_sar_q, idx_q, bus.gt_sin);
          if (idx_q == 4'd0) state_d = StDone;
          else               idx_d   = idx_q - 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        // Results, completion pulse and busy drop all appear in the cycle after DONE.
        state_d   = StIdle;
        cos_val_d = cos_sar_q;
        sin_val_d = sin_sar_q;
        cmplt_d   = 1'b1;
        busy_d    = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      idx_q     <= 4'd11;
      cos_sar_q <= 12'h000;
      sin_sar_q <= 12'h000;
      cos_val_q <= 12'h000;
      sin_val_q <= 12'h000;
      smpl_q    <= 1'b0;
      busy_q    <= 1'b0;
      cmplt_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cos_sar_q <= cos_sar_d;
      sin_sar_q <= sin_sar_d;
      cos_val_q <= cos_val_d;
      sin_val_q <= sin_val_d;
      smpl_q    <= smpl_d;
      busy_q    <= busy_d;
      cmplt_q   <= cmplt_d;
    end
  end

  assign bus.smpl      = smpl_q;
  assign bus.cosSAR    = cos_sar_q;
  assign bus.sinSAR    = sin_sar_q;
  assign bus.cos_val   = cos_val_q;
  assign bus.sin_val   = sin_val_q;
  assign bus.busy      = busy_q;
  assign bus.cnv_cmplt = cmplt_q;

endmodule

// File: tb/tb_atod_digital.sv
// Bench for atod_digital: default-parameter instance driven from a vector table plus
// hand-written corner sequences, and a SMPL_CYCLES=1/SETTLE=1 instance.
module tb_atod_digital;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  atod_digital_if bus ();
  atod_digital_if bus1 ();

  atod_digital #(.SMPL_CYCLES(4), .SETTLE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  atod_digital #(.SMPL_CYCLES(1), .SETTLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  // Analog front end: sample-and-hold on smpl falling edge, strict greater-than comparator.
  logic [11:0] cos_a = 12'h000, sin_a = 12'h000, cos_h = 12'h000, sin_h = 12'h000;
  logic [11:0] cos_a1 = 12'h000, sin_a1 = 12'h000, cos_h1 = 12'h000, sin_h1 = 12'h000;
  always @(negedge bus.smpl) begin
    cos_h = cos_a;
    sin_h = sin_a;
  end
  always @(negedge bus1.smpl) begin
    cos_h1 = cos_a1;
    sin_h1 = sin_a1;
  end
  assign bus.gt_cos  = (bus.cosSAR > cos_h);
  assign bus.gt_sin  = (bus.sinSAR > sin_h);
  assign bus1.gt_cos = (bus1.cosSAR > cos_h1);
  assign bus1.gt_sin = (bus1.sinSAR > sin_h1);

  typedef struct {
    logic [11:0] cos_a;
    logic [11:0] sin_a;
    logic [11:0] post_cos;  // analog value applied after smpl has fallen
    logic [11:0] post_sin;
    logic [11:0] exp_cos;
    logic [11:0] exp_sin;
  } vec_t;

  int n_pass = 0;
  int n_chk  = 0;
  logic [11:0] trace [0:40];

  task automatic check12(input string name, input logic [11:0] act, input logic [11:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %03h required %03h", name, act, req);
  endtask

  task automatic checki(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  // Entered #1 after the acceptance edge; k counts edges since acceptance.
  task automatic collect(input logic [11:0] post_cos, input logic [11:0] post_sin,
                         output int lat, output int scnt);
    lat  = 0;
    scnt = 0;
    trace[0] = bus.cosSAR;
    if (bus.smpl) scnt++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      trace[k] = bus.cosSAR;
      if (bus.smpl) scnt++;
      if (k == 6) begin
        cos_a = post_cos;
        sin_a = post_sin;
      end
      if (bus.cnv_cmplt) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_conv(input vec_t v);
    int lat, scnt;
    @(negedge clk);
    cos_a = v.cos_a;
    sin_a = v.sin_a;
    bus.strt_cnv = 1'b1;
    @(posedge clk);
    #1;
    bus.strt_cnv = 1'b0;
    collect(v.post_cos, v.post_sin, lat, scnt);
    checki("latency", lat, 29);
    checki("smpl_high_cycles", scnt, 4);
    check12("sar_zero_in_sample", trace[1], 12'h000);
    check12("cos_val", bus.cos_val, v.exp_cos);
    check12("sin_val", bus.sin_val, v.exp_sin);
    checki("busy_low_at_cmplt", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    checki("cmplt_one_cycle", int'(bus.cnv_cmplt), 0);
    check12("sar_holds_result", bus.cosSAR, v.exp_cos);
  endtask

  initial begin
    vec_t vecs [6];
    int lat, scnt, t1, t2, ncmp;
    logic [11:0] w;

    vecs[0] = '{12'h5A3, 12'hA5C, 12'h5A3, 12'hA5C, 12'h5A3, 12'hA5C};
    vecs[1] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
    vecs[2] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000};
    vecs[3] = '{12'h800, 12'h7FF, 12'h800, 12'h7FF, 12'h800, 12'h7FF};
    vecs[4] = '{12'h001, 12'hFFE, 12'h001, 12'hFFE, 12'h001, 12'hFFE};
    vecs[5] = '{12'h123, 12'hABC, 12'hEDC, 12'h543, 12'h123, 12'hABC};

    bus.strt_cnv  = 1'b0;
    bus1.strt_cnv = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checki("rst_smpl", int'(bus.smpl), 0);
    checki("rst_busy", int'(bus.busy), 0);
    checki("rst_cmplt", int'(bus.cnv_cmplt), 0);
    check12("rst_cosSAR", bus.cosSAR, 12'h000);
    check12("rst_sin_val", bus.sin_val, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i]);
      if (i == 1) begin
        // cos=0: every trial overshoots, so the trial word is a walking one.
        w = 12'h800;
        for (int j = 0; j < 12; j++) begin
          check12("cos_trial_seq", trace[4 + 2 * j], w >> j);
        end
      end
    end

    // Request held high: back-to-back conversions
    @(negedge clk);
    cos_a = 12'h3C7;
    sin_a = 12'h0F0;
    bus.strt_cnv = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (bus.cnv_cmplt) begin
        if (t1 < 0) t1 = k;
        else begin
          t2 = k;
          bus.strt_cnv = 1'b0;
          break;
        end
      end
    end
    bus.strt_cnv = 1'b0;
    checki("b2b_spacing", t2 - t1, 30);
    check12("b2b_cos_val", bus.cos_val, 12'h3C7);
    check12("b2b_sin_val", bus.sin_val, 12'h0F0);
    @(posedge clk);
    #1;
    checki("b2b_stops", int'(bus.busy), 0);

    // Second request mid-conversion is ignored
    @(negedge clk);
    cos_a = 12'h6B2;
    sin_a = 12'h19D;
    bus.strt_cnv = 1'b1;
    @(posedge clk);
    #1;
    bus.strt_cnv = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.strt_cnv = 1'b1;
    @(posedge clk);
    #1;
    bus.strt_cnv = 1'b0;
    ncmp = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (bus.cnv_cmplt) ncmp++;
    end
    checki("midconv_single_cmplt", ncmp, 1);
    check12("midconv_cos_val", bus.cos_val, 12'h6B2);
    checki("midconv_idle", int'(bus.busy), 0);

    // Reset during conversion at bit 6
    @(negedge clk);
    cos_a = 12'h7A1;
    sin_a = 12'h15E;
    bus.strt_cnv = 1'b1;
    @(posedge clk);
    #1;
    bus.strt_cnv = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check12("bit6_trial", bus.cosSAR & 12'h07F, 12'h040);
    rst_n = 1'b0;
    #1;
    checki("abort_smpl", int'(bus.smpl), 0);
    checki("abort_busy", int'(bus.busy), 0);
    checki("abort_cmplt", int'(bus.cnv_cmplt), 0);
    check12("abort_cosSAR", bus.cosSAR, 12'h000);
    check12("abort_sinSAR", bus.sinSAR, 12'h000);
    check12("abort_cos_val", bus.cos_val, 12'h000);
    check12("abort_sin_val", bus.sin_val, 12'h000);
    ncmp = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (bus.cnv_cmplt) ncmp++;
    end
    checki("abort_no_cmplt", ncmp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cos_a = 12'hC35;
    sin_a = 12'h2B9;
    bus.strt_cnv = 1'b1;
    @(posedge clk);
    #1;
    bus.strt_cnv = 1'b0;
    checki("accept_first_edge", int'(bus.busy), 1);
    collect(12'hC35, 12'h2B9, lat, scnt);
    checki("post_rst_latency", lat, 29);
    check12("post_rst_cos_val", bus.cos_val, 12'hC35);
    check12("post_rst_sin_val", bus.sin_val, 12'h2B9);

    // SMPL_CYCLES=1, SETTLE=1 instance
    @(negedge clk);
    cos_a1 = 12'h800;
    sin_a1 = 12'h3FF;
    bus1.strt_cnv = 1'b1;
    @(posedge clk);
    #1;
    bus1.strt_cnv = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus1.cnv_cmplt) begin
        lat = k;
        break;
      end
    end
    checki("fast_latency", lat, 14);
    check12("fast_cos_val", bus1.cos_val, 12'h800);
    check12("fast_sin_val", bus1.sin_val, 12'h3FF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
